// File: rtl/pu_or1k_fifo_ctrl_pkg.sv
// Shared sizing helpers for the PU first-word-fall-through FIFO controller.
package pu_or1k_fifo_pkg;

    // Extra count bit lets a completely full FIFO be told apart from an empty one.
    localparam int unsigned CNT_EXTRA_BITS = 1;

    function automatic int unsigned fifo_cap(input int unsigned depth_width);
        return 32'd1 << depth_width;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth_width);
        return depth_width + CNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/pu_or1k_fifo_ctrl_if.sv
// Producer/consumer handshake bundle of the FIFO controller.
interface pu_or1k_fifo_ctrl_if
    import pu_or1k_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic                                flush;
    logic [DATA_WIDTH-1:0]               wr_data;
    logic                                wr_valid;
    logic                                wr_ready;
    logic [DATA_WIDTH-1:0]               rd_data;
    logic                                rd_valid;
    logic                                rd_ready;
    logic [cnt_width(DEPTH_WIDTH)-1:0]   count;
    logic                                almost_full;

    modport master (
        output flush, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, count, almost_full
    );

    modport slave (
        input  flush, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, count, almost_full
    );

endinterface

// File: rtl/pu_or1k_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with a registered read port and optional
// write-to-read bypass.
module pu_or1k_simple_dpram_sclk #(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          ENABLE_BYPASS = 1'b1,
    parameter bit          CLEAR_ON_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);
    localparam int unsigned WORDS = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_bypass;

    // Power-up clearing needs an initialised array, which this target lacks.
    if (CLEAR_ON_INIT) begin : g_no_clear
        $error("pu_or1k_simple_dpram_sclk: CLEAR_ON_INIT is not supported");
    end

    assign w_bypass = ENABLE_BYPASS && i_we && (i_waddr == i_raddr);

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_dout <= w_bypass ? i_din : r_mem[i_raddr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/pu_or1k_fifo_ctrl.sv
// FWFT FIFO controller: pointers, occupancy and handshakes around one RAM whose
// registered read port serves as the output stage.
module pu_or1k_fifo_ctrl
    import pu_or1k_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ALMOST_FULL_LVL = fifo_cap(DEPTH_WIDTH) - 1
) (
    input logic                 clk,
    input logic                 rst,
    pu_or1k_fifo_ctrl_if.slave  io_fifo
);
    localparam int unsigned       CNT_W  = cnt_width(DEPTH_WIDTH);
    localparam logic [CNT_W-1:0]  CAP    = CNT_W'(fifo_cap(DEPTH_WIDTH));
    localparam logic [CNT_W-1:0]  AF_LVL = CNT_W'(ALMOST_FULL_LVL);

    logic [DEPTH_WIDTH-1:0] r_wr_ptr,   w_wr_ptr_nxt;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr,   w_rd_ptr_nxt;
    logic [CNT_W-1:0]       r_ram_cnt,  w_ram_cnt_nxt;
    logic                   r_rd_valid, w_rd_valid_nxt;

    logic [CNT_W-1:0]       w_count;
    logic                   w_wr_ready;
    logic                   w_push;
    logic                   w_re;

    assign w_count    = r_ram_cnt + CNT_W'(r_rd_valid);
    assign w_wr_ready = (w_count != CAP);

    // flush wins over both sides; the RAM ports are quiesced for that cycle.
    assign w_push = io_fifo.wr_valid & w_wr_ready & ~io_fifo.flush;
    assign w_re   = (r_ram_cnt != '0) & (~r_rd_valid | io_fifo.rd_ready) & ~io_fifo.flush;

    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_ram_cnt_nxt  = r_ram_cnt;
        w_rd_valid_nxt = r_rd_valid;
        if (io_fifo.flush) begin
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_ram_cnt_nxt  = '0;
            w_rd_valid_nxt = 1'b0;
        end else begin
            w_wr_ptr_nxt  = r_wr_ptr + DEPTH_WIDTH'(w_push);
            w_rd_ptr_nxt  = r_rd_ptr + DEPTH_WIDTH'(w_re);
            w_ram_cnt_nxt = r_ram_cnt + CNT_W'(w_push) - CNT_W'(w_re);
            if (w_re) begin
                w_rd_valid_nxt = 1'b1;
            end else if (io_fifo.rd_ready) begin
                w_rd_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Push and read can never hit the same entry, so no bypass path is needed.
    pu_or1k_simple_dpram_sclk #(
        .ADDR_WIDTH    (DEPTH_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .ENABLE_BYPASS (1'b0),
        .CLEAR_ON_INIT (1'b0)
    ) u_ram (
        .clk     (clk),
        .i_raddr (r_rd_ptr),
        .i_re    (w_re),
        .i_waddr (r_wr_ptr),
        .i_we    (w_push),
        .i_din   (io_fifo.wr_data),
        .o_dout  (io_fifo.rd_data)
    );

    assign io_fifo.wr_ready    = w_wr_ready;
    assign io_fifo.rd_valid    = r_rd_valid;
    assign io_fifo.count       = w_count;
    assign io_fifo.almost_full = (w_count >= AF_LVL);

endmodule

// File: tb/tb_pu_or1k_fifo_ctrl.sv
// Directed bench for pu_or1k_fifo_ctrl at capacity 4, almost-full level 3.
module tb_pu_or1k_fifo_ctrl;
    localparam int unsigned DW    = 2;
    localparam int unsigned DATAW = 8;
    localparam int unsigned AFL   = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pu_or1k_fifo_ctrl_if #(.DEPTH_WIDTH(DW), .DATA_WIDTH(DATAW)) fifo_if ();

    pu_or1k_fifo_ctrl #(
        .DEPTH_WIDTH     (DW),
        .DATA_WIDTH      (DATAW),
        .ALMOST_FULL_LVL (AFL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_fifo (fifo_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fifo_if.flush    = 1'b0;
        fifo_if.wr_valid = 1'b0;
        fifo_if.wr_data  = '0;
        fifo_if.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fifo_if.count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", fifo_if.count);
        end
        checks++;
        if (fifo_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd_valid: got %0b expected 0", fifo_if.rd_valid);
        end
        checks++;
        if (fifo_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready: got %0b expected 1", fifo_if.wr_ready);
        end
        checks++;
        if (fifo_if.almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_almost_full: got %0b expected 0", fifo_if.almost_full);
        end
        #5 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        fifo_if.wr_data  = 8'hA5;
        fifo_if.wr_valid = 1'b1;
        fifo_if.rd_ready = 1'b1;
        tick();
        fifo_if.wr_valid = 1'b0;
        checks++;
        if (fifo_if.rd_valid !== 1'b0 || fifo_if.count !== 3'd1) begin
            errors++; $display("FAIL single_c1: got valid=%0b count=%0d expected valid=0 count=1",
                               fifo_if.rd_valid, fifo_if.count);
        end
        tick();
        checks++;
        if (fifo_if.rd_valid !== 1'b1 || fifo_if.rd_data !== 8'hA5) begin
            errors++; $display("FAIL single_c2: got valid=%0b data=%0h expected valid=1 data=a5",
                               fifo_if.rd_valid, fifo_if.rd_data);
        end
        tick();
        checks++;
        if (fifo_if.rd_valid !== 1'b0 || fifo_if.count !== 3'd0) begin
            errors++; $display("FAIL single_c3: got valid=%0b count=%0d expected valid=0 count=0",
                               fifo_if.rd_valid, fifo_if.count);
        end
        idle();
    endtask

    task automatic test_fill();
        fifo_if.rd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            int exp_cnt;
            exp_cnt = (i < 4) ? i : 4;
            fifo_if.wr_data  = 8'(i);
            fifo_if.wr_valid = 1'b1;
            tick();
            checks++;
            if (fifo_if.count !== 3'(exp_cnt)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d",
                                   i, fifo_if.count, exp_cnt);
            end
            checks++;
            if (fifo_if.wr_ready !== (i < 4)) begin
                errors++; $display("FAIL fill_wr_ready[%0d]: got %0b expected %0b",
                                   i, fifo_if.wr_ready, (i < 4));
            end
            checks++;
            if (fifo_if.almost_full !== (i >= 3)) begin
                errors++; $display("FAIL fill_almost_full[%0d]: got %0b expected %0b",
                                   i, fifo_if.almost_full, (i >= 3));
            end
        end
        fifo_if.wr_valid = 1'b0;
        checks++;
        if (fifo_if.rd_valid !== 1'b1 || fifo_if.rd_data !== 8'h01) begin
            errors++; $display("FAIL fill_head: got valid=%0b data=%0h expected valid=1 data=1",
                               fifo_if.rd_valid, fifo_if.rd_data);
        end
    endtask

    task automatic test_drain();
        fifo_if.rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (fifo_if.rd_valid !== 1'b1 || fifo_if.rd_data !== 8'(i)
                || fifo_if.count !== 3'(5 - i)) begin
                errors++; $display("FAIL drain[%0d]: got valid=%0b data=%0h count=%0d expected 1 %0h %0d",
                                   i, fifo_if.rd_valid, fifo_if.rd_data, fifo_if.count, i, 5 - i);
            end
            tick();
        end
        checks++;
        if (fifo_if.rd_valid !== 1'b0 || fifo_if.count !== 3'd0 || fifo_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL drain_end: got valid=%0b count=%0d wr_ready=%0b expected 0 0 1",
                               fifo_if.rd_valid, fifo_if.count, fifo_if.wr_ready);
        end
        idle();
    endtask

    task automatic test_stream_wrap();
        int sent = 0;
        int got  = 0;
        fifo_if.rd_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            fifo_if.wr_valid = (sent < 20);
            fifo_if.wr_data  = 8'(sent);
            checks++;
            if (fifo_if.count > 3'd2) begin
                errors++; $display("FAIL stream_count: got %0d expected <=2", fifo_if.count);
            end
            if (fifo_if.rd_valid === 1'b1) begin
                checks++;
                if (fifo_if.rd_data !== 8'(got)) begin
                    errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h",
                                       got, fifo_if.rd_data, got);
                end
                got++;
            end
            if (fifo_if.wr_valid && fifo_if.wr_ready) sent++;
            tick();
        end
        checks++;
        if (got != 20) begin
            errors++; $display("FAIL stream_total: got %0d words expected 20", got);
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int sent = 0;
        int got  = 0;
        pat = 4'b1001;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            fifo_if.rd_ready = pat[cyc % 4];
            fifo_if.wr_valid = (sent < 8);
            fifo_if.wr_data  = 8'(8'h30 + sent);
            if (fifo_if.rd_valid === 1'b1) begin
                // Head must equal the next unconsumed word, held or not.
                checks++;
                if (fifo_if.rd_data !== 8'(8'h30 + got)) begin
                    errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h",
                                       got, fifo_if.rd_data, 8'h30 + got);
                end
                if (fifo_if.rd_ready) got++;
            end
            if (fifo_if.wr_valid && fifo_if.wr_ready) sent++;
            tick();
        end
        fifo_if.wr_valid = 1'b0;
        fifo_if.rd_ready = 1'b0;
        checks++;
        if (got != 8) begin
            errors++; $display("FAIL bp_total: got %0d words expected 8", got);
        end
        checks++;
        if (fifo_if.rd_valid !== 1'b0 || fifo_if.count !== 3'd0) begin
            errors++; $display("FAIL bp_end: got valid=%0b count=%0d expected 0 0",
                               fifo_if.rd_valid, fifo_if.count);
        end
        idle();
    endtask

    task automatic test_flush();
        int got = 0;
        fifo_if.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fifo_if.wr_data  = 8'(8'h51 + i);
            fifo_if.wr_valid = 1'b1;
            tick();
        end
        checks++;
        if (fifo_if.count !== 3'd3 || fifo_if.almost_full !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got count=%0d af=%0b expected 3 1",
                               fifo_if.count, fifo_if.almost_full);
        end
        fifo_if.flush   = 1'b1;
        fifo_if.wr_data = 8'hEE;
        checks++;
        if (fifo_if.wr_ready !== 1'b1) begin
            errors++; $display("FAIL flush_wr_ready: got %0b expected 1", fifo_if.wr_ready);
        end
        tick();
        fifo_if.flush    = 1'b0;
        fifo_if.wr_valid = 1'b0;
        checks++;
        if (fifo_if.count !== 3'd0 || fifo_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_post: got count=%0d valid=%0b expected 0 0",
                               fifo_if.count, fifo_if.rd_valid);
        end
        fifo_if.wr_data  = 8'h61;
        fifo_if.wr_valid = 1'b1;
        fifo_if.rd_ready = 1'b1;
        tick();
        fifo_if.wr_valid = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (fifo_if.rd_valid === 1'b1) begin
                checks++;
                if (got == 0 && fifo_if.rd_data !== 8'h61) begin
                    errors++; $display("FAIL flush_after_data: got %0h expected 61", fifo_if.rd_data);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 1) begin
            errors++; $display("FAIL flush_after_total: got %0d words expected 1", got);
        end
        idle();
    endtask

    task automatic test_async_reset();
        fifo_if.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_if.wr_data  = 8'(8'h71 + i);
            fifo_if.wr_valid = 1'b1;
            tick();
        end
        checks++;
        if (fifo_if.wr_ready !== 1'b0 || fifo_if.almost_full !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got wr_ready=%0b af=%0b expected 0 1",
                               fifo_if.wr_ready, fifo_if.almost_full);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (fifo_if.count !== 3'd0 || fifo_if.rd_valid !== 1'b0
            || fifo_if.wr_ready !== 1'b1 || fifo_if.almost_full !== 1'b0) begin
            errors++; $display("FAIL areset_now: got count=%0d valid=%0b wr_ready=%0b af=%0b expected 0 0 1 0",
                               fifo_if.count, fifo_if.rd_valid, fifo_if.wr_ready, fifo_if.almost_full);
        end
        fifo_if.wr_valid = 1'b0;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (fifo_if.count !== 3'd0 || fifo_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL areset_after: got count=%0d valid=%0b expected 0 0",
                               fifo_if.count, fifo_if.rd_valid);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_or1k_fifo_ctrl.md
Name: pu_or1k_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO controller that sequences one `pu_or1k_simple_dpram_sclk` instance.
- Owns the write/read pointers, the occupancy count and the valid/ready handshakes on both sides.
- The RAM's registered read port acts as the output stage.
- Used as the decoupling buffer between the PU store/refill paths and the Wishbone interface.

Parameters:
- DEPTH_WIDTH, 4: log2 of capacity. Capacity is 2**DEPTH_WIDTH entries; minimum 1.
- DATA_WIDTH, 32: width of stored words.
- ALMOST_FULL_LVL, (2**DEPTH_WIDTH)-1: almost_full asserts when count >= this value. Legal range 1..2**DEPTH_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous empty-the-FIFO command.
- wr_data  in  DATA_WIDTH  push data.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO can accept a push.
- rd_data  out  DATA_WIDTH  head-of-FIFO data; meaningful only while rd_valid=1.
- rd_valid  out  1  rd_data holds the head entry.
- rd_ready  in  1  consumer pops the head when rd_valid=1.
- count  out  DEPTH_WIDTH+1  total entries held (RAM plus output stage).
- almost_full  out  1  count >= ALMOST_FULL_LVL.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset state: all of the following are zero:
  - wr_ptr, rd_ptr, ram_cnt, rd_valid, count, almost_full.
  - wr_ready=1.
  - rd_data is undefined. RAM contents are not cleared (CLEAR_ON_INIT=0).
- Internal state:
  - wr_ptr, rd_ptr: DEPTH_WIDTH bits each; both wrap naturally from 2**DEPTH_WIDTH-1 to 0.
  - ram_cnt: DEPTH_WIDTH+1 bits; counts entries in RAM not yet read out.
  - rd_valid: flag for the output stage.
- Derived signals:
  - count = ram_cnt + rd_valid, saturating at 2**DEPTH_WIDTH by construction.
  - wr_ready = (count != 2**DEPTH_WIDTH). This is registered-state only; a pop in the same cycle does not raise wr_ready.
  - almost_full = (count >= ALMOST_FULL_LVL). Combinational from registered state.
- Push (push = wr_valid & wr_ready):
  - RAM write with we=push, waddr=wr_ptr, din=wr_data.
  - Then wr_ptr++ and ram_cnt++.
- RAM read issue: re = (ram_cnt != 0) & (~rd_valid | rd_ready), with raddr=rd_ptr. On re: rd_ptr++, ram_cnt--, rd_valid<=1.
- Pop without refill: rd_valid & rd_ready & ~re -> rd_valid<=0.
- Held head: rd_valid=1 with rd_ready=0 gives re=0, so the RAM holds rdata and rd_data stays stable.
- Simultaneous push and re: ram_cnt is unchanged (+1-1).
- Push and re can never address the same RAM entry:
  - Empty RAM means re=0.
  - Full FIFO means no push.
  - The RAM is therefore instantiated with ENABLE_BYPASS=0.
- Latency:
  - A push into an empty FIFO in cycle N gives rd_valid=1 in cycle N+2.
  - Back-to-back pops sustain one word per cycle while ram_cnt>0.
- flush:
  - Next edge: wr_ptr, rd_ptr, ram_cnt and rd_valid go to 0.
  - flush overrides any push or pop in the same cycle; a concurrent push is dropped.
  - wr_ready stays as computed from current state during the flush cycle.
- Reset mid-operation: immediate asynchronous return to the reset state; in-flight data is lost.
- Consumer side: rd_ready while rd_valid=0 is legal and has no effect.
- Producer side: wr_valid while wr_ready=0 is legal; the word is not accepted and the producer must hold it.

Decomposition:
- Package pu_or1k_fifo_pkg holds:
  - function fifo_cap(depth_width), returning 2**depth_width.
  - the count-width localparam rule (DEPTH_WIDTH+1).
- Sub-module: pu_or1k_simple_dpram_sclk with ADDR_WIDTH=DEPTH_WIDTH, DATA_WIDTH=DATA_WIDTH, ENABLE_BYPASS=0, CLEAR_ON_INIT=0.
- The controller itself is a single module with no FSM beyond the counters and the rd_valid flag.

Test Plan:
All tests use DEPTH_WIDTH=2 (capacity 4) and ALMOST_FULL_LVL=3 unless noted.
- Single word: push 0xA5 in cycle 0 with rd_ready=1 -> rd_valid=1 and rd_data=0xA5 in cycle 2, rd_valid=0 in cycle 3, count returns to 0.
- Fill: push 0x1..0x5 on consecutive cycles with rd_ready=0 -> 4 words accepted; wr_ready=0 from the cycle after the 4th accept; almost_full=1 when count=3; count=4; the 5th word is not accepted.
- Drain after fill: rd_ready=1 -> rd_data sequence 0x1,0x2,0x3,0x4 on four consecutive cycles, then rd_valid=0, count=0, wr_ready=1.
- Streaming with wrap: continuous push of 0..19 with rd_ready=1 -> all 20 words out in order; pointers wrap five times; count never exceeds 2.
- Backpressure: rd_ready toggled 1,0,0,1 while pushing -> rd_data held constant during rd_ready=0; no word lost or duplicated.
- Flush and reset:
  - With count=3, assert flush together with wr_valid -> next cycle count=0, rd_valid=0, and the pushed word is absent from later output.
  - Async rst asserted mid-stream between edges -> outputs go to reset values immediately.
